vga_timing_gen: RTL and testbench

//  Parametrised raster timing generator; successor to the fixed 800x600 sync block.
//  Any resolution/porch set, sync polarity and pixel clock-enable; registered outputs.

---
 rtl/vga_timing_pkg.sv | 39 +++
 rtl/vga_wrap_cnt.sv | 22 ++
 rtl/vga_timing_gen.sv | 109 ++++++++++
 tb/tb_vga_timing_gen.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Timing sets and decode helpers shared by the raster timing generator.
package vga_timing_pkg;

  localparam int SVGA_H_ACTIVE = 800;
  localparam int SVGA_H_FP     = 40;
  localparam int SVGA_H_SYNC   = 128;
  localparam int SVGA_H_BP     = 88;
  localparam int SVGA_V_ACTIVE = 600;
  localparam int SVGA_V_FP     = 1;
  localparam int SVGA_V_SYNC   = 4;
  localparam int SVGA_V_BP     = 23;

  localparam int VGA_H_ACTIVE  = 640;
  localparam int VGA_H_FP      = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BP      = 48;
  localparam int VGA_V_ACTIVE  = 480;
  localparam int VGA_V_FP      = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BP      = 33;

  function automatic int h_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int v_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  // Half-open span test [lo, hi); an empty span (lo >= hi) never matches.
  function automatic logic in_span(input int cnt, input int lo, input int hi);
    return (cnt >= lo) && (cnt < hi);
  endfunction

  function automatic logic sync_level(input logic on, input logic pol);
    return on ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_wrap_cnt.sv
// Enabled modulo-(MAX+1) counter; wrap flags the enabled step that returns to 0.
module vga_wrap_cnt #(
  parameter int CW  = 11,
  parameter int MAX = 1055
) (
  input  logic          clk,
  input  logic          w_rst,
  input  logic          ce,
  output logic [CW-1:0] cnt,
  output logic          wrap
);

  localparam logic [CW-1:0] LAST = CW'(MAX);

  assign wrap = ce && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (w_rst)   cnt <= '0;
    else if (ce) cnt <= wrap ? '0 : cnt + CW'(1);
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator with registered decode outputs.
// Optional VGA_TIMING_FRAME_CNT_EN adds a 16-bit frame counter port.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CW        = 11,
  parameter int H_ACTIVE  = SVGA_H_ACTIVE,
  parameter int H_FP      = SVGA_H_FP,
  parameter int H_SYNC    = SVGA_H_SYNC,
  parameter int H_BP      = SVGA_H_BP,
  parameter int V_ACTIVE  = SVGA_V_ACTIVE,
  parameter int V_FP      = SVGA_V_FP,
  parameter int V_SYNC    = SVGA_V_SYNC,
  parameter int V_BP      = SVGA_V_BP,
  parameter bit HS_POL    = 1'b1,
  parameter bit VS_POL    = 1'b1,
  parameter int WIN_Y_STA = 60,
  parameter int WIN_Y_END = 540
) (
  input  logic          clk,
  input  logic          w_rst,
  input  logic          ce,
  output logic [CW-1:0] pos_x,
  output logic [CW-1:0] pos_y,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic          window,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  logic [CW-1:0] hcnt, vcnt;
  logic          h_wrap, v_wrap;
  logic          origin;

  vga_wrap_cnt #(.CW(CW), .MAX(H_TOTAL-1)) u_hcnt (
    .clk(clk), .w_rst(w_rst), .ce(ce), .cnt(hcnt), .wrap(h_wrap)
  );

  vga_wrap_cnt #(.CW(CW), .MAX(V_TOTAL-1)) u_vcnt (
    .clk(clk), .w_rst(w_rst), .ce(h_wrap), .cnt(vcnt), .wrap(v_wrap)
  );

  // origin marks that the counters currently sit at (0,0).
  always_ff @(posedge clk) begin
    if (w_rst)   origin <= 1'b1;
    else if (ce) origin <= v_wrap;
  end

  logic h_act, v_act, act, hs_on, vs_on, win_on;

  always_comb begin
    h_act  = int'(hcnt) < H_ACTIVE;
    v_act  = int'(vcnt) < V_ACTIVE;
    act    = h_act && v_act;
    hs_on  = in_span(int'(hcnt), H_ACTIVE + H_FP, H_ACTIVE + H_FP + H_SYNC);
    vs_on  = in_span(int'(vcnt), V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC);
    win_on = act && in_span(int'(vcnt), WIN_Y_STA, WIN_Y_END);
  end

  always_ff @(posedge clk) begin
    if (w_rst) begin
      pos_x       <= '0;
      pos_y       <= '0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      active      <= 1'b0;
      window      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (ce) begin
      pos_x       <= act ? hcnt : '0;
      pos_y       <= act ? vcnt : '0;
      hsync       <= sync_level(hs_on, HS_POL);
      vsync       <= sync_level(vs_on, VS_POL);
      active      <= act;
      window      <= win_on;
      line_start  <= (hcnt == '0);
      frame_start <= origin;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  // The first frame after reset is frame 0, so skip the first origin.
  logic seen_frame;

  always_ff @(posedge clk) begin
    if (w_rst) begin
      frame_cnt  <= '0;
      seen_frame <= 1'b0;
    end else if (ce && origin) begin
      seen_frame <= 1'b1;
      if (seen_frame) frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: small timing set, normal and inverted-polarity/degenerate-window instances.
module tb_vga_timing_gen;

  localparam int CW = 8;
  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 12, VF = 1, VS = 2, VB = 2;
  localparam int WS = 3, WE = 9;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  typedef struct packed {
    logic [CW-1:0] px;
    logic [CW-1:0] py;
    logic hs, vs, act, win, ls, fs;
  } obs_t;

  logic clk = 1'b0, rst = 1'b1, ce = 1'b0;
  logic [CW-1:0] px1, py1, px2, py2;
  logic hs1, vs1, a1, w1, ls1, fs1;
  logic hs2, vs2, a2, w2, ls2, fs2;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] fc1, fc2;
`endif
  obs_t o1, o2;

  always #5 clk = ~clk;

  vga_timing_gen #(.CW(CW), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .HS_POL(1'b1), .VS_POL(1'b1),
    .WIN_Y_STA(WS), .WIN_Y_END(WE)) dut (
    .clk(clk), .w_rst(rst), .ce(ce), .pos_x(px1), .pos_y(py1), .hsync(hs1), .vsync(vs1),
    .active(a1), .window(w1), .line_start(ls1), .frame_start(fs1)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(fc1)
`endif
  );

  vga_timing_gen #(.CW(CW), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .HS_POL(1'b0), .VS_POL(1'b0),
    .WIN_Y_STA(WE), .WIN_Y_END(WS)) dut_inv (
    .clk(clk), .w_rst(rst), .ce(ce), .pos_x(px2), .pos_y(py2), .hsync(hs2), .vsync(vs2),
    .active(a2), .window(w2), .line_start(ls2), .frame_start(fs2)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(fc2)
`endif
  );

  assign o1 = {px1, py1, hs1, vs1, a1, w1, ls1, fs1};
  assign o2 = {px2, py2, hs2, vs2, a2, w2, ls2, fs2};

  int mh = 0, mv = 0, lh = -1, lv = -1, cyc = 0;
  int n_chk = 0, n_pass = 0;
  obs_t e1, e2, x1, x2;
  obs_t q1[$], q2[$];

  function automatic obs_t decode(input int h, input int v, input bit hp, input bit vp,
                                  input int ws, input int we);
    obs_t o;
    bit a;
    a     = (h < HA) && (v < VA);
    o.px  = a ? CW'(h) : '0;
    o.py  = a ? CW'(v) : '0;
    o.hs  = (h >= HA + HF && h < HA + HF + HS) ? hp : !hp;
    o.vs  = (v >= VA + VF && v < VA + VF + VS) ? vp : !vp;
    o.act = a;
    o.win = a && v >= ws && v < we;
    o.ls  = (h == 0);
    o.fs  = (h == 0) && (v == 0);
    return o;
  endfunction

  function automatic obs_t idle(input bit hp, input bit vp);
    obs_t o;
    o    = '0;
    o.hs = !hp;
    o.vs = !vp;
    return o;
  endfunction

  // Drive one clock of stimulus and queue what both instances must show afterwards.
  task automatic step(input bit r, input bit c);
    rst = r;
    ce  = c;
    if (r) begin
      e1 = idle(1'b1, 1'b1); e2 = idle(1'b0, 1'b0);
      mh = 0; mv = 0; lh = -1; lv = -1;
    end else if (c) begin
      lh = mh; lv = mv;
      e1 = decode(mh, mv, 1'b1, 1'b1, WS, WE);
      e2 = decode(mh, mv, 1'b0, 1'b0, WE, WS);
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else mh++;
    end else begin
      e1.ls = 1'b0; e1.fs = 1'b0; e2.ls = 1'b0; e2.fs = 1'b0;
      lh = -1; lv = -1;
    end
    q1.push_back(e1);
    q2.push_back(e2);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0);
      x1 = q1.pop_front(); x2 = q2.pop_front(); n_chk++;
      if (o1 !== x1 || o2 !== x2)
        $display("FAIL sb_reset cyc=%0d got %h/%h want %h/%h", cyc, o1, o2, x1, x2);
      else n_pass++;
    end
    n_chk++;
    if (hs1 !== 1'b0 || vs1 !== 1'b0 || hs2 !== 1'b1 || vs2 !== 1'b1)
      $display("FAIL reset_sync_idle got hs/vs=%b%b inv=%b%b want 00 inv 11", hs1, vs1, hs2, vs2);
    else n_pass++;
    step(1'b0, 1'b1);
    x1 = q1.pop_front(); x2 = q2.pop_front(); n_chk++;
    if (o1 !== x1 || o2 !== x2)
      $display("FAIL sb_first cyc=%0d got %h/%h want %h/%h", cyc, o1, o2, x1, x2);
    else n_pass++;
    n_chk++;
    if (px1 !== 0 || py1 !== 0 || a1 !== 1'b1 || fs1 !== 1'b1 || ls1 !== 1'b1 ||
        hs1 !== 1'b0 || vs1 !== 1'b0)
      $display("FAIL first_ce got pos=(%0d,%0d) act=%b ls=%b fs=%b hs=%b vs=%b want (0,0) 1 1 1 0 0",
               px1, py1, a1, ls1, fs1, hs1, vs1);
    else n_pass++;
  endtask

  task automatic test_continuous();
    int last_ls = -1, last_fs = -1, hs_cnt = 0, vs_lines = 0, first_vs = -1;
    for (int i = 0; i < 2 * HT * VT; i++) begin
      step(1'b0, 1'b1);
      x1 = q1.pop_front(); x2 = q2.pop_front(); n_chk++;
      if (o1 !== x1 || o2 !== x2)
        $display("FAIL sb_cont cyc=%0d got %h/%h want %h/%h", cyc, o1, o2, x1, x2);
      else n_pass++;
      if (ls1) begin
        if (last_ls >= 0) begin
          n_chk++;
          if (cyc - last_ls != HT) $display("FAIL line_period got %0d want %0d", cyc - last_ls, HT);
          else n_pass++;
        end
        last_ls = cyc;
      end
      if (fs1) begin
        if (last_fs >= 0) begin
          n_chk++;
          if (cyc - last_fs != HT * VT)
            $display("FAIL frame_period got %0d want %0d", cyc - last_fs, HT * VT);
          else n_pass++;
        end
        last_fs = cyc;
      end
      if (lv == 0 && hs1 === 1'b1) hs_cnt++;
      if (lh == 0 && vs1 === 1'b1) begin
        vs_lines++;
        if (first_vs < 0) first_vs = lv;
      end
      if (lh == 0 && (lv == WS - 1 || lv == WE)) begin
        n_chk++;
        if (w1 !== 1'b0) $display("FAIL window_out row=%0d got %b want 0", lv, w1);
        else n_pass++;
      end
      if (lh == 0 && (lv == WS || lv == WE - 1)) begin
        n_chk++;
        if (w1 !== 1'b1) $display("FAIL window_in row=%0d got %b want 1", lv, w1);
        else n_pass++;
      end
      if (w2 !== 1'b0) begin
        n_chk++;
        $display("FAIL window_degenerate row=%0d got %b want 0", lv, w2);
      end
    end
    n_chk++;
    if (hs_cnt != 2 * HS) $display("FAIL hsync_width got %0d want %0d", hs_cnt, 2 * HS);
    else n_pass++;
    n_chk++;
    if (vs_lines != 2 * VS || first_vs != VA + VF)
      $display("FAIL vsync_lines got %0d first %0d want %0d first %0d", vs_lines, first_vs,
               2 * VS, VA + VF);
    else n_pass++;
  endtask

  task automatic test_ce_toggle();
    int last_ls = -1;
    for (int i = 0; i < 8 * HT; i++) begin
      step(1'b0, (i % 2) == 0);
      x1 = q1.pop_front(); x2 = q2.pop_front(); n_chk++;
      if (o1 !== x1 || o2 !== x2)
        $display("FAIL sb_toggle cyc=%0d got %h/%h want %h/%h", cyc, o1, o2, x1, x2);
      else n_pass++;
      if ((i % 2) == 1) begin
        n_chk++;
        if (ls1 !== 1'b0 || fs1 !== 1'b0)
          $display("FAIL strobe_width got ls=%b fs=%b want 0 0", ls1, fs1);
        else n_pass++;
      end
      if (ls1) begin
        if (last_ls >= 0) begin
          n_chk++;
          if (cyc - last_ls != 2 * HT)
            $display("FAIL toggle_line_period got %0d want %0d", cyc - last_ls, 2 * HT);
          else n_pass++;
        end
        last_ls = cyc;
      end
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    while (!(mh == HA + HF + 1 && mv == 6) && guard < 2 * HT * VT) begin
      step(1'b0, 1'b1);
      void'(q1.pop_front()); void'(q2.pop_front());
      guard++;
    end
    step(1'b0, 1'b1);
    x1 = q1.pop_front(); x2 = q2.pop_front(); n_chk++;
    if (o1 !== x1 || o2 !== x2 || hs1 !== 1'b1)
      $display("FAIL mid_in_sync got %h/%h want %h/%h", o1, o2, x1, x2);
    else n_pass++;
    step(1'b1, 1'b1);
    x1 = q1.pop_front(); x2 = q2.pop_front(); n_chk++;
    if (o1 !== x1 || o2 !== x2 || hs1 !== 1'b0)
      $display("FAIL mid_reset got %h/%h want %h/%h", o1, o2, x1, x2);
    else n_pass++;
    step(1'b0, 1'b1);
    x1 = q1.pop_front(); x2 = q2.pop_front(); n_chk++;
    if (o1 !== x1 || o2 !== x2 || px1 !== 0 || py1 !== 0 || fs1 !== 1'b1)
      $display("FAIL mid_restart got %h/%h want %h/%h", o1, o2, x1, x2);
    else n_pass++;
  endtask

`ifdef VGA_TIMING_FRAME_CNT_EN
  task automatic test_frame_cnt();
    step(1'b1, 1'b0);
    for (int i = 0; i < 3 * HT * VT + 1; i++) begin
      step(1'b0, 1'b1);
      if (i == 0) begin
        n_chk++;
        if (fc1 !== 16'd0) $display("FAIL frame_cnt_first got %0d want 0", fc1);
        else n_pass++;
      end
    end
    q1.delete(); q2.delete();
    n_chk++;
    if (fc1 !== 16'd3 || fc2 !== 16'd3)
      $display("FAIL frame_cnt got %0d/%0d want 3", fc1, fc2);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_continuous();
    test_ce_toggle();
    test_reset_mid();
`ifdef VGA_TIMING_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
